muldiv_ctrl: RTL and testbench

- Sequences the HI/LO arithmetic resource for MULT, MULTU, DIV and DIVU issued from the EX stage.
- Contains a 2-cycle multiply path and a 32-iteration restoring radix-2 divider.
- Holds the pipeline through stall_o while an operation is in flight, then presents a 64-bit {hi,lo} result with a one-cycle done strobe for the HI/LO register write.
- cancel (exception/flush) aborts any in-flight operation.

---
 rtl/muldiv_ctrl_pkg.sv | 7 +
 rtl/muldiv_ctrl_if.sv | 14 +
 rtl/muldiv_ctrl_div_iter.sv | 18 +
 rtl/muldiv_ctrl.sv | 93 +++++++++
 tb/tb_muldiv_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared HI/LO unit widths, op encodings and FSM states
package muldiv_ctrl_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_DIV_ITER = 32;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_MUL = 2'b01, ST_DIV = 2'b10, ST_DONE = 2'b11} md_state_e;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage mult/div request and HI/LO result bundle
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cancel;
  logic stall_o;
  logic done;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (output start, op, a, b, cancel, input stall_o, done, hi_o, lo_o);
  modport slave (input start, op, a, b, cancel, output stall_o, done, hi_o, lo_o);
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: one restoring shift/subtract step of {rem,quot} against the divisor
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq,
  input  logic [WIDTH-1:0]   dv,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] top;
  logic [WIDTH-1:0] rem;
  logic ge;
  always_comb begin
    top = rq[2*WIDTH-1:WIDTH-1];
    ge = top >= {1'b0, dv};
    rem = top[WIDTH-1:0] - dv;
    nxt = ge ? {rem, rq[WIDTH-2:0], 1'b1} : {rq[2*WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences 2-cycle multiply and 32-step restoring divide into HI/LO
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int DIV_ITER = MD_DIV_ITER
) (
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);
  md_state_e state;
  logic [WIDTH-1:0] ma, mb, dv, abs_a, abs_b, q, r;
  logic [2*WIDTH-1:0] rq, rq_nxt, pa, pb, prod;
  logic [CW-1:0] cnt;
  logic sgn, neg_q, neg_r, done_r, is_signed;
  div_iter #(.WIDTH(WIDTH)) u_iter (.rq(rq), .dv(dv), .nxt(rq_nxt));
  always_comb begin
    is_signed = ~bus.op[0];
    abs_a = is_signed & bus.a[WIDTH-1] ? -bus.a : bus.a;
    abs_b = is_signed & bus.b[WIDTH-1] ? -bus.b : bus.b;
    pa = {{WIDTH{sgn & ma[WIDTH-1]}}, ma};
    pb = {{WIDTH{sgn & mb[WIDTH-1]}}, mb};
    prod = pa * pb;
    q = neg_q ? -rq_nxt[WIDTH-1:0] : rq_nxt[WIDTH-1:0];
    r = neg_r ? -rq_nxt[2*WIDTH-1:WIDTH] : rq_nxt[2*WIDTH-1:WIDTH];
    bus.stall_o = bus.start & (state != ST_DONE) & ~bus.cancel & ~rst;
    bus.done = done_r & ~bus.cancel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done_r <= 1'b0;
      bus.hi_o <= '0;
      bus.lo_o <= '0;
      ma <= '0;
      mb <= '0;
      dv <= '0;
      rq <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (bus.cancel) begin
      state <= ST_IDLE;
      done_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          if (!bus.op[1]) begin
            ma <= bus.a;
            mb <= bus.b;
            sgn <= is_signed;
            state <= ST_MUL;
          end else if (bus.b == '0) begin
            bus.hi_o <= bus.a;
            bus.lo_o <= '1;
            done_r <= 1'b1;
            state <= ST_DONE;
          end else begin
            dv <= abs_b;
            rq <= {{WIDTH{1'b0}}, abs_a};
            neg_r <= is_signed & bus.a[WIDTH-1];
            neg_q <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt <= '0;
            state <= ST_DIV;
          end
        end
        ST_MUL: begin
          {bus.hi_o, bus.lo_o} <= prod;
          done_r <= 1'b1;
          state <= ST_DONE;
        end
        ST_DIV: begin
          rq <= rq_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.hi_o <= r;
            bus.lo_o <= q;
            done_r <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          done_r <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  muldiv_ctrl_if #(.WIDTH(32)) bus ();
  muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [63:0] res, input bit keep);
    int n = 0;
    bit stall_ok = 1'b1;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    while (!bus.done && n < 60) begin
      stall_ok &= bus.stall_o;
      n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " stall busy"}, 64'(stall_ok), 64'd1);
    chk({tag, " stall done"}, 64'(bus.stall_o), 64'd0);
    chk({tag, " hilo"}, {bus.hi_o, bus.lo_o}, res);
    @(posedge clk);
    #1;
    if (!keep) bus.start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b1;
    bus.cancel = 1'b0;
    bus.op = 2'b00;
    bus.a = 32'h0;
    bus.b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("reset stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    run("mult", 2'b00, 32'hFFFFFFFE, 32'h3, 2, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
    run("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 64'hFFFFFFFE_00000001, 1'b0);
    run("div", 2'b10, 32'hFFFFFFF9, 32'h2, 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run("div posneg", 2'b10, 32'h7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, 1'b0);
    run("divu", 2'b11, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);
    run("divu big", 2'b11, 32'hFFFFFFFF, 32'h80000001, 33, 64'h7FFFFFFE_00000001, 1'b0);
    run("div zero", 2'b10, 32'h12345678, 32'h0, 1, 64'h12345678_FFFFFFFF, 1'b0);
    run("div min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, 1'b0);
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    chk("cancel stall", 64'(bus.stall_o), 64'd0);
    chk("cancel done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("post cancel done", 64'(bus.done), 64'd0);
    chk("post cancel hilo", {bus.hi_o, bus.lo_o}, 64'h00000000_80000000);
    @(posedge clk);
    #1;
    run("multu after cancel", 2'b01, 32'd3, 32'd5, 2, 64'd15, 1'b0);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd2;
    bus.b = 32'd2;
    @(negedge clk);
    chk("idle cancel stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle cancel done", 64'(bus.done), 64'd0);
    chk("idle cancel hilo", {bus.hi_o, bus.lo_o}, 64'd15);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.a = 32'd50;
    bus.b = 32'd5;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("rst idle stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    run("b2b first", 2'b00, 32'd6, 32'd7, 2, 64'd42, 1'b1);
    run("b2b second", 2'b00, 32'hFFFFFFFD, 32'd5, 2, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
